// File: rtl/cpu_pkg.sv
// Shared decode types and constants for the ALU issue slice.
// Holds opcode/funct3 encodings and the D-stage decode helper.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef struct packed {
    logic [4:0]      rd;
    logic [2:0]      operation;
    logic [6:0]      metadata;
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic            illegal;
  } decoded_t;

  function automatic decoded_t decode(
    input logic [31:0]     ins,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    decoded_t   d;
    logic [2:0] f3;
    logic       sh;
    d           = '0;
    f3          = ins[14:12];
    sh          = (f3 == F3_SLL) || (f3 == F3_SR);
    d.rd        = ins[11:7];
    d.operation = f3;
    d.lhs       = a;
    unique case (1'b1)
      ins[6:0] == OPCODE_OP: begin
        d.metadata = ins[31:25];
        d.rhs      = sh ? XLEN'(b[4:0]) : b;
      end
      ins[6:0] == OPCODE_OP_IMM: begin
        d.metadata = sh ? ins[31:25] : 7'd0;
        d.rhs      = sh ? XLEN'(ins[24:20])
                        : {{(XLEN-12){ins[31]}},
                           ins[31:20]};
      end
      ins[6:0] == OPCODE_LUI: begin
        d.operation = 3'd0;
        d.lhs       = '0;
        d.rhs       = {ins[31:12], 12'b0};
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction, ALU and writeback bundle for alu_issue.
// slave is the issue block side, master the environment.
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [DATA_WIDTH-1:0] alu_lhs;
  logic [DATA_WIDTH-1:0] alu_rhs;
  logic [2:0]            alu_operation;
  logic [6:0]            alu_metadata;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_valid;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_illegal;

  modport slave (
    input  instr_valid, instr,
    input  alu_result, alu_valid, wb_ready,
    output instr_ready,
    output alu_lhs, alu_rhs,
    output alu_operation, alu_metadata,
    output wb_valid, wb_rd, wb_data, wb_illegal
  );

  modport master (
    output instr_valid, instr,
    output alu_result, alu_valid, wb_ready,
    input  instr_ready,
    input  alu_lhs, alu_rhs,
    input  alu_operation, alu_metadata,
    input  wb_valid, wb_rd, wb_data, wb_illegal
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: two async reads, one write.
// x0 reads as zero and is never written.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++)
        regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_issue.sv
// Decode/operand-fetch/writeback wrapper around the integer ALU.
// D register feeds the ALU; W register holds the committed result.
module alu_issue
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int REG_COUNT  = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_issue_if.slave   bus
);

  decoded_t              d_q;
  decoded_t              d_n;
  logic                  d_valid;
  logic                  w_valid;
  logic [4:0]            w_rd;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_illegal;

  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [DATA_WIDTH-1:0] rf_rd1;
  logic [DATA_WIDTH-1:0] rf_rd2;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  w_free;
  logic                  d_adv;
  logic                  commit;
  logic                  rf_we;
  logic                  accept;

  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign w_free = !w_valid || bus.wb_ready;
  assign d_adv  = d_valid && w_free;
  assign commit = !d_q.illegal && bus.alu_valid;
  assign rf_we  = d_adv && commit
               && (d_q.rd != 5'd0);
  assign accept = bus.instr_valid
               && bus.instr_ready;

  // The write landing this edge is invisible to the
  // async read, so bypass it from the ALU result.
  assign op1 = (rf_we && rs1 == d_q.rd)
             ? bus.alu_result : rf_rd1;
  assign op2 = (rf_we && rs2 == d_q.rd)
             ? bus.alu_result : rf_rd2;
  assign d_n = decode(bus.instr, op1, op2);

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (rf_we),
    .waddr  (d_q.rd),
    .wdata  (bus.alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid   <= 1'b0;
      d_q       <= '0;
      w_valid   <= 1'b0;
      w_rd      <= '0;
      w_data    <= '0;
      w_illegal <= 1'b0;
    end else begin
      if (accept) begin
        d_valid <= 1'b1;
        d_q     <= d_n;
      end else if (d_adv) begin
        d_valid <= 1'b0;
      end
      if (d_adv) begin
        w_valid   <= 1'b1;
        w_rd      <= d_q.rd;
        w_data    <= commit ? bus.alu_result : '0;
        w_illegal <= !commit;
      end else if (bus.wb_ready) begin
        w_valid <= 1'b0;
      end
    end
  end

  assign bus.instr_ready   = !d_valid || w_free;
  assign bus.alu_lhs       = d_q.lhs;
  assign bus.alu_rhs       = d_q.rhs;
  assign bus.alu_operation = d_q.operation;
  assign bus.alu_metadata  = d_q.metadata;
  assign bus.wb_valid      = w_valid;
  assign bus.wb_rd         = w_rd;
  assign bus.wb_data       = w_data;
  assign bus.wb_illegal    = w_illegal;

endmodule
